// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer with a registered output stage.
// Arbitration is round-robin (mode_i=0) or fixed lowest-index priority (mode_i=1).
module rr_arb_mux #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 4,
   parameter int IDX_W  = $clog2(NUM_CH)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    mode_i,
   input  logic [NUM_CH-1:0]       valid_i,
   input  logic [NUM_CH*WIDTH-1:0] data_i,
   output logic [NUM_CH-1:0]       ready_o,
   output logic                    valid_o,
   output logic [WIDTH-1:0]        data_o,
   output logic [IDX_W-1:0]        ch_o,
   input  logic                    ready_i
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [IDX_W-1:0] ch_q, ch_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   logic             load;
   logic             any_valid;
   logic             hi_found;
   logic [IDX_W-1:0] hi_idx;
   logic [IDX_W-1:0] lo_idx;
   logic [IDX_W-1:0] gnt_idx;
   logic             xfer;
   logic [WIDTH-1:0] ch_data [NUM_CH];

   for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
      assign ch_data[k] = data_i[k*WIDTH +: WIDTH];
   end

   assign load = !valid_q || ready_i;

   // Round-robin wrap without modulo: prefer the lowest requester at or above
   // ptr, otherwise fall back to the lowest requester overall.
   always_comb begin
      any_valid = 1'b0;
      hi_found  = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (valid_i[k]) begin
            any_valid = 1'b1;
            lo_idx    = IDX_W'(k);
            if (!mode_i && (k >= int'(ptr_q))) begin
               hi_found = 1'b1;
               hi_idx   = IDX_W'(k);
            end
         end
      end
      gnt_idx = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      ready_o = '0;
      if (!rst_i && load && any_valid) begin
         ready_o[gnt_idx] = 1'b1;
      end
   end

   assign xfer = |(valid_i & ready_o);

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ch_d    = ch_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         valid_d = 1'b1;
         data_d  = ch_data[gnt_idx];
         ch_d    = gnt_idx;
         if (!mode_i) begin
            ptr_d = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ch_q    <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         ptr_q   <= ptr_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign ch_o    = ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
`timescale 1ns/1ps
module tb_rr_arb_mux;

   localparam int WIDTH  = 32;
   localparam int NUM_CH = 4;
   localparam int IDX_W  = 2;

   logic                    clk_i = 1'b0;
   logic                    rst_i = 1'b1;
   logic                    mode_i = 1'b0;
   logic [NUM_CH-1:0]       valid_i = '0;
   logic [NUM_CH*WIDTH-1:0] data_i = '0;
   logic [NUM_CH-1:0]       ready_o;
   logic                    valid_o;
   logic [WIDTH-1:0]        data_o;
   logic [IDX_W-1:0]        ch_o;
   logic                    ready_i = 1'b0;

   int errors = 0;
   int checks = 0;

   rr_arb_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .mode_i  (mode_i),
      .valid_i (valid_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .data_o  (data_o),
      .ch_o    (ch_o),
      .ready_i (ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: output register, valid flag and rotating pointer.
   logic             m_valid = 1'b0;
   logic [WIDTH-1:0] m_data  = '0;
   int               m_ch    = 0;
   int               m_ptr   = 0;

   function automatic int winner();
      int k;
      if (valid_i == '0) return -1;
      for (int off = 0; off < NUM_CH; off++) begin
         k = mode_i ? off : (m_ptr + off) % NUM_CH;
         if (valid_i[k]) return k;
      end
      return -1;
   endfunction

   function automatic logic [NUM_CH-1:0] model_ready();
      int w;
      w = winner();
      if (rst_i || (m_valid && !ready_i) || w < 0) return '0;
      return NUM_CH'(1) << w;
   endfunction

   always @(posedge clk_i or posedge rst_i) begin
      int w;
      if (rst_i) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_ch    = 0;
         m_ptr   = 0;
      end else begin
         w = winner();
         if ((!m_valid || ready_i) && w >= 0) begin
            m_valid = 1'b1;
            m_data  = data_i[w*WIDTH +: WIDTH];
            m_ch    = w;
            if (!mode_i) m_ptr = (w + 1) % NUM_CH;
         end else if (m_valid && ready_i) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk_i) begin
      check_output("model ready_o", 64'(ready_o), 64'(model_ready()));
      check_output("model valid_o", 64'(valid_o), 64'(m_valid));
      if (m_valid || rst_i) begin
         check_output("model data_o", 64'(data_o), 64'(m_data));
         check_output("model ch_o", 64'(ch_o), 64'(m_ch));
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_stimulus(input logic mode, input logic [NUM_CH-1:0] valid, input logic rdy);
      mode_i  = mode;
      valid_i = valid;
      ready_i = rdy;
   endtask

   initial begin
      logic [NUM_CH-1:0] acc;
      data_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

      // Reset state, with requests present to show ready_o is held low.
      apply_stimulus(1'b0, 4'b1111, 1'b1);
      @(negedge clk_i);
      check_output("reset valid_o", 64'(valid_o), 64'd0);
      check_output("reset data_o", 64'(data_o), 64'd0);
      check_output("reset ch_o", 64'(ch_o), 64'd0);
      check_output("reset ready_o", 64'(ready_o), 64'd0);
      tick();
      rst_i = 1'b0;

      // Single request from ch2.
      apply_stimulus(1'b0, 4'b0100, 1'b1);
      @(negedge clk_i);
      check_output("t1 ready_o", 64'(ready_o), 64'h4);
      tick();
      apply_stimulus(1'b0, 4'b1111, 1'b1);
      @(negedge clk_i);
      check_output("t1 valid_o", 64'(valid_o), 64'd1);
      check_output("t1 data_o", 64'(data_o), 64'h3333_3333);
      check_output("t1 ch_o", 64'(ch_o), 64'd2);
      check_output("t1 ptr3 ready_o", 64'(ready_o), 64'h8);

      // Round-robin fairness with all channels valid.
      tick();
      @(negedge clk_i);
      check_output("t2 ch_o first", 64'(ch_o), 64'd3);
      check_output("t2 wrap ready_o", 64'(ready_o), 64'h1);
      for (int i = 0; i < 8; i++) begin
         tick();
         @(negedge clk_i);
         check_output("t2 ch_o", 64'(ch_o), 64'(i % 4));
         check_output("t2 data_o", 64'(data_o), 64'(32'h1111_1111 * (i % 4 + 1)));
         check_output("t2 valid_o", 64'(valid_o), 64'd1);
      end

      // Fixed priority: ch1 always beats ch3.
      tick();
      apply_stimulus(1'b1, 4'b1010, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk_i);
         check_output("t3 ch_o", 64'(ch_o), 64'd1);
         check_output("t3 data_o", 64'(data_o), 64'h2222_2222);
         check_output("t3 ready_o", 64'(ready_o), 64'h2);
      end

      // Backpressure with a held ch0 beat, then same-cycle refill.
      tick();
      apply_stimulus(1'b0, 4'b0001, 1'b1);
      @(negedge clk_i);
      check_output("t4 ready_o ch0", 64'(ready_o), 64'h1);
      tick();
      apply_stimulus(1'b0, 4'b0010, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check_output("t4 stall ready_o", 64'(ready_o), 64'h0);
         check_output("t4 stall ch_o", 64'(ch_o), 64'd0);
         check_output("t4 stall data_o", 64'(data_o), 64'h1111_1111);
         check_output("t4 stall valid_o", 64'(valid_o), 64'd1);
         tick();
      end
      ready_i = 1'b1;
      @(negedge clk_i);
      check_output("t4 refill ready_o", 64'(ready_o), 64'h2);
      tick();
      apply_stimulus(1'b0, 4'b0000, 1'b1);
      @(negedge clk_i);
      check_output("t4 ch_o", 64'(ch_o), 64'd1);
      check_output("t4 valid_o", 64'(valid_o), 64'd1);
      check_output("t4 data_o", 64'(data_o), 64'h2222_2222);

      // Drain to empty, then ch3 request and pointer wrap.
      tick();
      @(negedge clk_i);
      check_output("t5 drained valid_o", 64'(valid_o), 64'd0);
      tick();
      apply_stimulus(1'b0, 4'b1000, 1'b1);
      @(negedge clk_i);
      check_output("t5 ready_o", 64'(ready_o), 64'h8);
      tick();
      apply_stimulus(1'b0, 4'b1111, 1'b1);
      @(negedge clk_i);
      check_output("t5 ch_o", 64'(ch_o), 64'd3);
      check_output("t5 data_o", 64'(data_o), 64'h4444_4444);
      check_output("t5 wrap ready_o", 64'(ready_o), 64'h1);

      // Asynchronous reset between edges while ch2 is held.
      tick();
      tick();
      tick();
      @(negedge clk_i);
      check_output("t6 pre ch_o", 64'(ch_o), 64'd2);
      check_output("t6 pre valid_o", 64'(valid_o), 64'd1);
      #2 rst_i = 1'b1;
      #1;
      check_output("t6 async valid_o", 64'(valid_o), 64'd0);
      check_output("t6 async data_o", 64'(data_o), 64'd0);
      check_output("t6 async ch_o", 64'(ch_o), 64'd0);
      check_output("t6 async ready_o", 64'(ready_o), 64'd0);
      rst_i = 1'b0;
      #1;
      check_output("t6 release ready_o", 64'(ready_o), 64'h1);
      @(negedge clk_i);
      check_output("t6 first ch_o", 64'(ch_o), 64'd0);
      check_output("t6 first data_o", 64'(data_o), 64'h1111_1111);

      // Mixed traffic obeying the hold-until-accepted rule, checked by the model.
      for (int n = 0; n < 60; n++) begin
         @(negedge clk_i);
         acc = valid_i & ready_o;
         tick();
         for (int k = 0; k < NUM_CH; k++) begin
            if (!valid_i[k] || acc[k]) begin
               valid_i[k] = 1'($urandom_range(0, 1));
               data_i[k*WIDTH +: WIDTH] = $urandom;
            end
         end
         ready_i = ($urandom_range(0, 3) != 0);
         mode_i  = ($urandom_range(0, 4) == 0);
      end
      @(negedge clk_i);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel arbitrating multiplexer with a registered output stage; successor to the combinational 4-input select mux.
- Used where several producers compete for one consumer, e.g. memory-port sharing between fetch, load/store and debug.
- Arbitration is round-robin or fixed-priority, selected at runtime.
- Each side uses a valid/ready handshake; the output carries the winning channel index alongside the data.

Parameters:
- WIDTH, 32, data width per channel in bits.
- NUM_CH, 4, number of input channels; must be at least 2.
- IDX_W, $clog2(NUM_CH), width of the channel index. Derived; do not override.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- mode_i  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- valid_i  input  NUM_CH  per-channel request valid.
- data_i  input  NUM_CH*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- ready_o  output  NUM_CH  per-channel accept; one-hot or zero.
- valid_o  output  1  output register holds a valid beat.
- data_o  output  WIDTH  registered data of the granted channel.
- ch_o  output  IDX_W  index of the channel that produced data_o.
- ready_i  input  1  downstream accepts the beat when valid_o is high.

Behaviour:
- Reset (async assert, sync-released use):
  - valid_o=0, data_o=0, ch_o=0, priority pointer ptr=0.
  - ready_o is all zero while rst_i is high.
  - Asserting reset mid-transfer discards the held beat; no partial state survives.
- Load enable: load = !valid_o || ready_i. The output stage may refill in the same cycle it drains, so full throughput is 1 beat/cycle.
- Arbitration is combinational over valid_i:
  - mode_i=0: search starts at ptr and wraps modulo NUM_CH; the first asserted channel wins.
  - mode_i=1: the lowest asserted index wins; ptr is ignored.
  - No valid_i asserted: no grant, ready_o=0.
- ready_o[g] = load && grant[g]. A transfer from channel g occurs when valid_i[g] && ready_o[g].
- On a transfer at edge t:
  - data_o <= data_i[g], ch_o <= g, valid_o <= 1 (visible at t+1).
  - Latency is 1 cycle input-to-output.
- Pointer update:
  - On a transfer with mode_i=0: ptr <= (g+1) mod NUM_CH; wraps from NUM_CH-1 to 0.
  - mode_i=1: ptr holds.
  - No transfer: ptr holds.
- Drain with no new transfer: when valid_o && ready_i and there is no winner, valid_o <= 0. data_o and ch_o keep their last values; they are don't-care while valid_o=0.
- Stall: when valid_o && !ready_i, load=0 and ready_o=0. data_o, ch_o and valid_o hold stable until accepted.
- Input rule: once a channel raises valid_i, it holds valid_i and data stable until its ready_o is seen. The block does not buffer rejected requests.
- A mode_i change takes effect on the next arbitration; there is no pipeline flush.
- Fairness: in round-robin with all channels continuously valid and ready_i=1, grants cycle 0,1,...,NUM_CH-1,0 with no channel skipped.
- Only the output register, valid_o and ptr are state; there are no other counters.

Test Plan:
1. Reset, then valid_i=4'b0100, data ch2=32'h3333_3333, ready_i=1 -> ready_o=4'b0100 the same cycle; next cycle valid_o=1, data_o=32'h3333_3333, ch_o=2; ptr=3.
2. Round-robin fairness: mode_i=0, valid_i=4'b1111 held, channel data 32'h1111_1111..32'h4444_4444, ready_i=1 for 8 cycles -> ch_o sequence 0,1,2,3,0,1,2,3 with matching data; valid_o=1 every cycle after the first.
3. Fixed priority: mode_i=1, valid_i=4'b1010 held -> every beat ch_o=1, data_o=ch1 data; channel 3 is never granted while channel 1 is valid.
4. Backpressure: a beat from ch0 is held, ready_i=0 for 3 cycles, valid_i=4'b0010 -> ready_o=0, data_o and ch_o stable for 3 cycles; on ready_i=1 the same-cycle refill gives ch_o=1 on the next cycle with no bubble.
5. Drain to empty: valid_o=1, ready_i=1, valid_i=0 -> next cycle valid_o=0, ptr unchanged; then valid_i=4'b1000 -> ch_o=3, and ptr wraps to 0.
6. Async reset mid-stream: rst_i pulsed between clock edges while valid_o=1, ch_o=2 -> valid_o=0, data_o=0, ch_o=0 immediately (before the next edge); the first grant after release with valid_i=4'b1111 is ch0.
